// File: rtl/adder_share_arb.sv
// Two-requester round-robin arbiter feeding a shared add/sub/pass datapath.
// It has an operand stage (S1), a result stage (S2) and a valid/ready result port.
module adder_share_arb #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic [1:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic [1:0]   req1_op,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_data,
   output logic         res_carry,
   output logic         res_id,
   output logic         busy
);

   typedef enum logic [1:0] {
      OP_PASS_A = 2'b00,
      OP_PASS_B = 2'b01,
      OP_ADD    = 2'b10,
      OP_SUB    = 2'b11
   } op_e;

   // S1 operand register
   logic [N-1:0] s1_a_q, s1_a_d;
   logic [N-1:0] s1_b_q, s1_b_d;
   op_e          s1_op_q, s1_op_d;
   logic         s1_id_q, s1_id_d;
   logic         s1_v_q, s1_v_d;

   // S2 result register
   logic [N-1:0] s2_data_q, s2_data_d;
   logic         s2_carry_q, s2_carry_d;
   logic         s2_id_q, s2_id_d;
   logic         s2_v_q, s2_v_d;

   logic         last_q, last_d;

   logic         adv1, adv2;
   logic         grant, grant_valid, xfer;
   logic [N-1:0] b_eff;
   logic [N:0]   sum;

   assign adv2        = !s2_v_q || res_ready;
   assign adv1        = !s1_v_q || adv2;
   assign grant_valid = req0_valid || req1_valid;
   // A lone requester always wins; on contention the one not served last wins.
   assign grant       = (req0_valid && req1_valid) ? !last_q : req1_valid;
   assign xfer        = adv1 && grant_valid;

   assign req0_ready = xfer && !grant;
   assign req1_ready = xfer &&  grant;

   // The adder sees only S1, so it is quiet unless a request was accepted.
   assign b_eff = (s1_op_q == OP_SUB) ? ~s1_b_q : s1_b_q;
   assign sum   = {1'b0, s1_a_q} + {1'b0, b_eff} + {{N{1'b0}}, (s1_op_q == OP_SUB)};

   always_comb begin
      // NOTE: every signal gets a hold default first so no latch is inferred.
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s1_id_d    = s1_id_q;
      s1_v_d     = s1_v_q;
      s2_data_d  = s2_data_q;
      s2_carry_d = s2_carry_q;
      s2_id_d    = s2_id_q;
      s2_v_d     = s2_v_q;
      last_d     = last_q;

      if (xfer) begin
         s1_a_d  = grant ? req1_a : req0_a;
         s1_b_d  = grant ? req1_b : req0_b;
         s1_op_d = op_e'(grant ? req1_op : req0_op);
         s1_id_d = grant;
         s1_v_d  = 1'b1;
         last_d  = grant;
      end else if (adv2) begin
         s1_v_d = 1'b0;
      end

      if (adv2) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_id_d = s1_id_q;
            unique case (s1_op_q)
               OP_PASS_A: begin s2_data_d = s1_a_q;     s2_carry_d = 1'b0;   end
               OP_PASS_B: begin s2_data_d = s1_b_q;     s2_carry_d = 1'b0;   end
               default:   begin s2_data_d = sum[N-1:0]; s2_carry_d = sum[N]; end
            endcase
         end
      end
   end

   // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         s2_data_q  <= '0;
         s2_carry_q <= 1'b0;
         s2_id_q    <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         s1_v_q     <= s1_v_d;
         s2_v_q     <= s2_v_d;
         s2_data_q  <= s2_data_d;
         s2_carry_q <= s2_carry_d;
         s2_id_q    <= s2_id_d;
         last_q     <= last_d;
      end
   end

   // NOTE: operand registers carry no reset; s1_v_q masks their stale contents.
   always_ff @(posedge clk) begin
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_op_q <= s1_op_d;
      s1_id_q <= s1_id_d;
   end

   assign res_valid = s2_v_q;
   assign res_data  = s2_data_q;
   assign res_carry = s2_carry_q;
   assign res_id    = s2_id_q;
   assign busy      = s1_v_q || s2_v_q;

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Two-requester arbiter and sequencer for the shared N-bit add/pass datapath. It grants one requester per cycle using round-robin priority and captures the winner's operands into an isolated operand register. It computes pass-A, pass-B, A+B or A−B in a registered result stage and returns the result, tagged with the requester ID, over a valid/ready handshake. Adder inputs change only on an accepted request, so the datapath does not toggle while idle.

## Interface
Parameters:
- N, 32, operand/result width (≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle when high with req0_valid
- req0_a  in  N  requester 0 operand A
- req0_b  in  N  requester 0 operand B
- req0_op  in  2  requester 0 operation: 00 pass A, 01 pass B, 10 A+B, 11 A−B
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  N  result, modulo 2^N
- res_carry  out  1  carry-out for A+B; no-borrow (A≥B unsigned) for A−B; 0 for pass ops
- res_id  out  1  ID of the requester that issued the result
- busy  out  1  high when either pipeline stage holds a valid entry

## Operation
- Two stages:
  - S1 is the operand register: a, b, op, id, s1_v.
  - S2 is the result register: data, carry, id, s2_v.
  - res_valid = s2_v; busy = s1_v | s2_v.
- Stall rules:
  - adv2 = !s2_v | res_ready (S2 can load).
  - adv1 = !s1_v | adv2 (S1 can load).
- Arbitration, combinational from req*_valid and pointer `last`:
  - Only one requester valid: grant it.
  - Both valid: grant !last.
  - grant_valid = req0_valid | req1_valid.
- reqX_ready = adv1 & grant_valid & (grant == X). The non-granted ready is 0. Neither ready is ever high for a requester whose valid is low.
- Transfer: at the edge where reqX_valid & reqX_ready, S1 loads that requester's a/b/op and id = X, s1_v ← 1, last ← X. `last` changes on no other event.
- S1 → S2 when s1_v & adv2. S2 loads f(S1) and s1_v is cleared, unless a new transfer reloads S1 at the same edge.
- S2 holds data/carry/id while res_valid & !res_ready. It clears s2_v on res_ready unless S1 is advancing into it.
- Arithmetic:
  - A+B: {carry, data} = a + b, (N+1)-bit.
  - A−B: data = a + ~b + 1 (mod 2^N); carry = the carry-out of that sum.
- Operand isolation: S1 operand registers load only on a transfer. The adder is driven only from S1, never from the req ports.
- Requesters must hold valid and payload stable until accepted. Dropping valid before acceptance is permitted; the request is then simply not serviced.
- The path res_ready → reqX_ready is combinational (full throughput). The path reqX_valid → reqX_ready is combinational through the grant.

## Timing
- Reset: s1_v = s2_v = 0, last = 1 (requester 0 has first priority), res_data = 0, res_carry = 0, res_id = 0, busy = 0. S1 contents may be left stale but must not be observable.
- Reset mid-operation discards all in-flight entries. No result is emitted for them.
- Latency: a transfer at edge k gives res_valid high from edge k+1 to k+2, then S2 loads at edge k+1… precisely: S1 loads at edge k, S2 loads at edge k+1, and res_valid is high in the cycle after edge k+1. Latency is 2 edges with no backpressure.
- Throughput: one request per cycle with res_ready held high.
- Full: both stages valid and res_ready = 0 drives both readies to 0. A res_ready pulse frees exactly one slot the same cycle.
- Simultaneous requests with continuous valids alternate grants 0, 1, 0, 1 …
- When only one requester is valid, it wins every cycle regardless of `last`.

## Test plan
- Single request, add: req0 a=5, b=7, op=10, res_ready=1 → req0_ready=1 at cycle 0; res_valid=1 two edges later with data=12, carry=0, id=0; busy clears after the handshake.
- Wrap and subtract: N=32, a=FFFFFFFF, b=00000001, op=10 → data=0, carry=1. Then a=3, b=5, op=11 → data=FFFFFFFE, carry=0. Then a=5, b=3, op=11 → data=2, carry=1.
- Round-robin: both requesters valid for 6 cycles with distinct operands → grants 0,1,0,1,0,1; res_id follows the same order and each result matches its operands.
- Backpressure: 3 back-to-back req0 adds with res_ready=0 → two accepted, then req0_ready=0. res_data holds the first result stable. Raise res_ready → results drain in order with no loss or duplication, and the third request is accepted the same cycle.
- Pass ops and isolation: op=00 with a=AAAA5555 → data=AAAA5555, carry=0; op=01 → data=b. With both requesters idle and changing a/b, the S1 operand registers do not change.
- Reset mid-op: assert rst for 1 cycle while s1_v=s2_v=1 → next cycle res_valid=0, busy=0, and res_data=0. With both requesters valid, the first grant goes to requester 0.
